// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates the single pipelined 16-bit main memory between
//                the I-cache fill FSM, the D-cache fill FSM and D-cache
//                write-through stores. A granted fill owns memory for a whole
//                block: the arbiter issues the block's word reads back-to-back
//                and routes each returning valid to the owning cache.
//  Options     : MEM_ARB_RR_EN - when defined, ties between the two fill
//                requesters go to the one not served by the most recent fill.
//                When undefined, the D-cache always beats the I-cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  // I-cache fill requester
  input  logic        icache_req,
  input  logic [15:0] icache_addr,
  output logic        icache_grant,
  output logic        icache_data_valid,
  // D-cache fill requester
  input  logic        dcache_req,
  input  logic [15:0] dcache_addr,
  output logic        dcache_grant,
  output logic        dcache_data_valid,
  // D-cache write-through store requester
  input  logic        dwrite_req,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  output logic        dwrite_ack,
  // Memory side
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic        mem_data_valid
);

  // Byte offset bits inside a block and counter width able to hold BLOCK_WORDS
  localparam int              c_OFF_BITS  = $clog2(BLOCK_WORDS * 2);
  localparam int              c_CNT_W     = $clog2(BLOCK_WORDS) + 1;
  localparam logic [c_CNT_W-1:0] c_BLOCK_CNT = c_CNT_W'(BLOCK_WORDS);
  localparam logic [15:0]     c_OFF_MASK  = 16'((1 << c_OFF_BITS) - 1);

  // Elaboration-time sanity checks on the configuration
  generate
    if (BLOCK_WORDS < 2 || BLOCK_WORDS > 16 ||
        (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_block_words
      $error("mem_arbiter: BLOCK_WORDS must be a power of two in 2..16");
    end
    if (MEM_LATENCY < 1) begin : g_bad_mem_latency
      $error("mem_arbiter: MEM_LATENCY must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_IFILL = 2'd2,
    ST_DFILL = 2'd3
  } state_t;

  state_t             state_q,     state_d;
  logic [15:0]        base_q,      base_d;
  logic [c_CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [c_CNT_W-1:0] recv_cnt_q,  recv_cnt_d;

  logic               w_fill;
  logic               w_issuing;
  logic               w_pick_d;
  logic [c_CNT_W-1:0] w_recv_inc;

`ifdef MEM_ARB_RR_EN
  // 1 = the most recent fill served the I-cache
  logic               last_fill_i_q, last_fill_i_d;
`endif

  assign w_fill     = (state_q == ST_IFILL) || (state_q == ST_DFILL);
  assign w_issuing  = w_fill && (issue_cnt_q != c_BLOCK_CNT);
  assign w_recv_inc = recv_cnt_q + c_CNT_W'(1);

  // Fill tie-break: decides whether the D-cache wins when no store is pending
`ifdef MEM_ARB_RR_EN
  assign w_pick_d = dcache_req && (!icache_req || last_fill_i_q);
`else
  assign w_pick_d = dcache_req;
`endif

  // Next-state, block base latch and issue/receive counter updates
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
`ifdef MEM_ARB_RR_EN
    last_fill_i_d = last_fill_i_q;
`endif
    case (state_q)
      ST_IDLE: begin
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
        if (dwrite_req) begin
          state_d = ST_WRITE;
        end else if (w_pick_d) begin
          state_d = ST_DFILL;
          base_d  = dcache_addr & ~c_OFF_MASK;
`ifdef MEM_ARB_RR_EN
          last_fill_i_d = 1'b0;
`endif
        end else if (icache_req) begin
          state_d = ST_IFILL;
          base_d  = icache_addr & ~c_OFF_MASK;
`ifdef MEM_ARB_RR_EN
          last_fill_i_d = 1'b1;
`endif
        end
      end
      ST_WRITE: begin
        // A store occupies memory for exactly one cycle
        state_d = ST_IDLE;
      end
      ST_IFILL, ST_DFILL: begin
        if (issue_cnt_q != c_BLOCK_CNT) begin
          issue_cnt_d = issue_cnt_q + c_CNT_W'(1);
        end
        // Completion is counted, not timed: the last returned word ends the fill
        if (mem_data_valid) begin
          recv_cnt_d = w_recv_inc;
          if (w_recv_inc == c_BLOCK_CNT) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_fill_i_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
`ifdef MEM_ARB_RR_EN
      last_fill_i_q <= last_fill_i_d;
`endif
    end
  end

  // Grants, ack and data-valid routing decoded from the registered state
  always_comb begin
    icache_grant      = (state_q == ST_IFILL);
    dcache_grant      = (state_q == ST_DFILL);
    dwrite_ack        = (state_q == ST_WRITE);
    icache_data_valid = (state_q == ST_IFILL) && mem_data_valid;
    dcache_data_valid = (state_q == ST_DFILL) && mem_data_valid;
  end

  // Memory request drive: one store cycle, or back-to-back block word reads
  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    if (state_q == ST_WRITE) begin
      mem_enable  = 1'b1;
      mem_wr      = 1'b1;
      mem_addr    = dwrite_addr;
      mem_data_in = dwrite_data;
    end else if (w_issuing) begin
      mem_enable  = 1'b1;
      mem_addr    = base_q + (16'(issue_cnt_q) << 1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a small
//                pipelined read-latency memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_req, dcache_req, dwrite_req;
  logic [15:0] icache_addr, dcache_addr, dwrite_addr, dwrite_data;
  logic        icache_grant, icache_data_valid;
  logic        dcache_grant, dcache_data_valid;
  logic        dwrite_ack;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_data_in;

  mem_arbiter #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .icache_req       (icache_req),
    .icache_addr      (icache_addr),
    .icache_grant     (icache_grant),
    .icache_data_valid(icache_data_valid),
    .dcache_req       (dcache_req),
    .dcache_addr      (dcache_addr),
    .dcache_grant     (dcache_grant),
    .dcache_data_valid(dcache_data_valid),
    .dwrite_req       (dwrite_req),
    .dwrite_addr      (dwrite_addr),
    .dwrite_data      (dwrite_data),
    .dwrite_ack       (dwrite_ack),
    .mem_enable       (mem_enable),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_data_valid   (mem_data_valid)
  );

  always #5 clk = ~clk;

  // Memory model: a read issued in cycle c returns its valid in cycle c+MEM_LATENCY
  logic [MEM_LATENCY-1:0] rd_pipe = '0;
  always @(posedge clk) rd_pipe <= {rd_pipe[MEM_LATENCY-2:0], mem_enable & ~mem_wr};
  assign mem_data_valid = rd_pipe[MEM_LATENCY-1];

  int          n_tests = 0;
  int          n_fail  = 0;

  // Per-test observation state
  int          cyc;
  logic [15:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  int          ev_code_q[$];  // 1 = store ack, 2 = D grant rise, 3 = I grant rise
  int          ev_cyc_q[$];
  int          n_dv, n_iv, n_ack, dg_cycles, ig_cycles;
  int          last_dv_cyc, last_iv_cyc, last_dg_cyc, last_ig_cyc, ack_cyc;
  int          data_in_viol;
  logic [15:0] wr_addr_s, wr_data_s;
  logic        wr_en_s;
  logic        s_dg, s_ig, s_ack, s_en, prev_dg, prev_ig;
  bit          auto_drop;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0;
    rd_addr_q.delete(); rd_cyc_q.delete();
    ev_code_q.delete(); ev_cyc_q.delete();
    n_dv = 0; n_iv = 0; n_ack = 0; dg_cycles = 0; ig_cycles = 0;
    last_dv_cyc = -1; last_iv_cyc = -1; last_dg_cyc = -1; last_ig_cyc = -1;
    ack_cyc = -1; data_in_viol = 0;
    wr_addr_s = '0; wr_data_s = '0; wr_en_s = 1'b0;
  endtask

  // Sample one cycle at the falling edge, then step to just after the next rising edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_dg  = dcache_grant;
    s_ig  = icache_grant;
    s_ack = dwrite_ack;
    s_en  = mem_enable;
    if (mem_enable && !mem_wr) begin
      rd_addr_q.push_back(mem_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (!mem_wr && mem_data_in != 16'h0) data_in_viol++;
    if (dcache_data_valid) begin n_dv++; last_dv_cyc = cyc; end
    if (icache_data_valid) begin n_iv++; last_iv_cyc = cyc; end
    if (s_dg) begin
      dg_cycles++; last_dg_cyc = cyc;
      if (!prev_dg) begin ev_code_q.push_back(2); ev_cyc_q.push_back(cyc); end
    end
    if (s_ig) begin
      ig_cycles++; last_ig_cyc = cyc;
      if (!prev_ig) begin ev_code_q.push_back(3); ev_cyc_q.push_back(cyc); end
    end
    if (s_ack) begin
      n_ack++; ack_cyc = cyc;
      ev_code_q.push_back(1); ev_cyc_q.push_back(cyc);
      wr_en_s = mem_enable && mem_wr; wr_addr_s = mem_addr; wr_data_s = mem_data_in;
    end
    prev_dg = s_dg;
    prev_ig = s_ig;
    @(posedge clk);
    #1;
    if (auto_drop) begin
      if (s_dg) dcache_req = 1'b0;
      if (s_ig) icache_req = 1'b0;
    end
    if (s_ack) dwrite_req = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!dcache_req && !icache_req && !dwrite_req && !s_dg && !s_ig && !s_ack) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, int'(done), 1);
  endtask

  task automatic check_fill(input bit is_d, input logic [15:0] base, input string tag);
    logic [15:0] exp_addr;
    chk({tag, "_nreads"}, rd_addr_q.size(), BLOCK_WORDS);
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      if (k < rd_addr_q.size()) begin
        exp_addr = base + 16'(2 * k);
        chk($sformatf("%s_rd%0d", tag, k), int'(rd_addr_q[k]), int'(exp_addr));
      end
    end
    if (rd_cyc_q.size() > 0)
      chk({tag, "_rd_span"}, rd_cyc_q[rd_cyc_q.size()-1] - rd_cyc_q[0], BLOCK_WORDS - 1);
    chk({tag, "_own_valids"},   is_d ? n_dv : n_iv, BLOCK_WORDS);
    chk({tag, "_other_valids"}, is_d ? n_iv : n_dv, 0);
    chk({tag, "_grant_cycles"}, is_d ? dg_cycles : ig_cycles, BLOCK_WORDS + MEM_LATENCY);
    chk({tag, "_drop_on_last"}, is_d ? (last_dg_cyc - last_dv_cyc) : (last_ig_cyc - last_iv_cyc), 0);
    chk({tag, "_wdata_zero"},   data_in_viol, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    icache_req = 1'b0; dcache_req = 1'b0; dwrite_req = 1'b0;
    icache_addr = '0; dcache_addr = '0; dwrite_addr = '0; dwrite_data = '0;
    auto_drop = 1'b1; prev_dg = 1'b0; prev_ig = 1'b0;
    clear_stats();

    // Reset state
    repeat (3) tick();
    chk("reset_ctrl", int'({icache_grant, icache_data_valid, dcache_grant, dcache_data_valid,
                            dwrite_ack, mem_enable, mem_wr}), 0);
    chk("reset_addr_data", int'({mem_addr, mem_data_in}), 0);
    rst = 1'b0;
    tick();

    // D-cache fill from an unaligned address
    clear_stats();
    dcache_req = 1'b1; dcache_addr = 16'h1236;
    tick();
    chk("dfill_grant_idle", int'(s_dg), 0);
    tick();
    chk("dfill_grant_next", int'(s_dg), 1);
    run_until_idle(40, "dfill");
    check_fill(1'b1, 16'h1230, "dfill");

    // I-cache fill at the last word of a block
    clear_stats();
    icache_req = 1'b1; icache_addr = 16'hABCF;
    run_until_idle(40, "ifill");
    check_fill(1'b0, 16'hABC0, "ifill");

    // All three requesters at once: store, then D fill, then I fill
    clear_stats();
    dwrite_req = 1'b1; dwrite_addr = 16'h0040; dwrite_data = 16'hBEEF;
    dcache_req = 1'b1; dcache_addr = 16'h0800;
    icache_req = 1'b1; icache_addr = 16'h0900;
    run_until_idle(80, "simul");
    chk("simul_nevents", ev_code_q.size(), 3);
    if (ev_code_q.size() >= 3) begin
      chk("simul_first_write", ev_code_q[0], 1);
      chk("simul_second_dfill", ev_code_q[1], 2);
      chk("simul_third_ifill", ev_code_q[2], 3);
      chk("simul_w_to_d_gap", ev_cyc_q[1] - ev_cyc_q[0], 2);
      chk("simul_d_to_i_gap", ev_cyc_q[2] - ev_cyc_q[1], BLOCK_WORDS + MEM_LATENCY + 1);
    end
    chk("simul_nack", n_ack, 1);
    chk("simul_wr_strobe", int'(wr_en_s), 1);
    chk("simul_wr_addr", int'(wr_addr_s), 16'h0040);
    chk("simul_wr_data", int'(wr_data_s), 16'hBEEF);
    chk("simul_dvalids", n_dv, BLOCK_WORDS);
    chk("simul_ivalids", n_iv, BLOCK_WORDS);

    // Store arriving mid-fill waits until the fill has completed
    clear_stats();
    dcache_req = 1'b1; dcache_addr = 16'h2000;
    repeat (4) tick();
    dwrite_req = 1'b1; dwrite_addr = 16'h0100; dwrite_data = 16'h1234;
    run_until_idle(60, "wmid");
    check_fill(1'b1, 16'h2000, "wmid_fill");
    chk("wmid_nack", n_ack, 1);
    chk("wmid_ack_delay", ack_cyc - last_dg_cyc, 2);
    chk("wmid_wr_addr", int'(wr_addr_s), 16'h0100);
    chk("wmid_wr_data", int'(wr_data_s), 16'h1234);

    // Reset in the cycle carrying the third valid abandons the fill
    clear_stats();
    icache_req = 1'b1; icache_addr = 16'h4000;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (n_iv == 2) break;
    end
    chk("rst_pre_valids", n_iv, 2);
    rst = 1'b1;
    tick();
    chk("rst_third_valid", n_iv, 3);
    rst = 1'b0;
    tick();
    chk("rst_outs_after", int'({s_ig, s_dg, s_en, s_ack}), 0);
    repeat (10) tick();
    chk("rst_stale_ivalids", n_iv, 3);
    chk("rst_stale_dvalids", n_dv, 0);
    clear_stats();
    dcache_req = 1'b1; dcache_addr = 16'h5006;
    tick();
    tick();
    chk("rst_next_grant", int'(s_dg), 1);
    run_until_idle(40, "rstnext");
    check_fill(1'b1, 16'h5000, "rstnext");

    // Both fill requesters held continuously
    clear_stats();
    auto_drop = 1'b0;
    dcache_req = 1'b1; dcache_addr = 16'h3000;
    icache_req = 1'b1; icache_addr = 16'h6000;
    repeat (50) tick();
    dcache_req = 1'b0; icache_req = 1'b0;
    auto_drop = 1'b1;
    run_until_idle(40, "tie");
    chk("tie_nfills", int'(ev_code_q.size() >= 4), 1);
    if (ev_code_q.size() >= 4) begin
`ifdef MEM_ARB_RR_EN
      chk("tie_fill0", ev_code_q[0], 2);
      chk("tie_fill1", ev_code_q[1], 3);
      chk("tie_fill2", ev_code_q[2], 2);
      chk("tie_fill3", ev_code_q[3], 3);
`else
      chk("tie_fill0", ev_code_q[0], 2);
      chk("tie_fill1", ev_code_q[1], 2);
      chk("tie_fill2", ev_code_q[2], 2);
      chk("tie_fill3", ev_code_q[3], 2);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single 16-bit unified main memory (4-cycle read latency, pipelined, one request per cycle) between three requesters: the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.
- A granted fill owns memory for a whole block. The arbiter itself issues the block's word reads back-to-back and routes each returning valid to the owning cache.
- Sits between both caches' miss controllers and the memory model. Its grant outputs feed the pipeline stall logic.

Parameters:
BLOCK_WORDS, 8, 2-byte words per cache block; power of two, 2..16; block offset = log2(BLOCK_WORDS*2) address bits.
MEM_LATENCY, 4, memory read latency in cycles; informational only, the arbiter counts returned valids and does not time them.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
icache_req  input  1  I-cache fill request, level, held until grant
icache_addr  input  16  I-cache miss address
icache_grant  output  1  I-cache owns memory (fill in progress)
icache_data_valid  output  1  memory word valid for I-cache this cycle
dcache_req  input  1  D-cache fill request, level
dcache_addr  input  16  D-cache miss address
dcache_grant  output  1  D-cache owns memory
dcache_data_valid  output  1  memory word valid for D-cache
dwrite_req  input  1  write-through store request, held until ack
dwrite_addr  input  16  store address
dwrite_data  input  16  store data
dwrite_ack  output  1  one-cycle pulse: store issued to memory
mem_enable  output  1  memory request strobe
mem_wr  output  1  1 = write, 0 = read
mem_addr  output  16  memory address
mem_data_in  output  16  memory write data
mem_data_valid  input  1  read data valid from memory

Behaviour:
- Reset. All outputs are 0, state is IDLE, and issue/receive counters are 0. Reset mid-fill abandons the fill. Valids still in flight arriving afterwards are dropped; neither *_data_valid asserts.

- States are IDLE, WRITE, IFILL and DFILL.
  - Grants and the ack are decoded from the registered state.
  - A request seen in IDLE is therefore granted the next cycle.

- IDLE priority (fixed): dwrite_req > dcache_req > icache_req.
  - IDLE→WRITE: dwrite_req.
  - IDLE→DFILL: dcache_req and no dwrite_req.
  - IDLE→IFILL: icache_req only.
  - Entering a fill latches base = {addr[15:off], off'b0} from the winner's address.

- WRITE (exactly 1 cycle):
  - mem_enable=1, mem_wr=1, mem_addr=dwrite_addr, mem_data_in=dwrite_data, dwrite_ack=1.
  - Next state is IDLE.
  - Stores are never issued while fill reads are outstanding.

- IFILL/DFILL, read issue:
  - The owner's grant is 1 for the whole state.
  - Read k (k=0..BLOCK_WORDS-1) issues with mem_enable=1, mem_wr=0, mem_addr=base+2k, one per cycle, starting the first cycle in the state.
  - The issue counter saturates at BLOCK_WORDS; mem_enable is 0 after that.

- IFILL/DFILL, data return:
  - Each mem_data_valid pulses the owner's *_data_valid in the same cycle (combinational) and increments the receive counter.
  - When the receive counter reaches BLOCK_WORDS, the next state is IDLE and the grant drops that cycle.
  - Fill length = BLOCK_WORDS + MEM_LATENCY cycles in the state.

- Request changes mid-fill:
  - Requests arriving mid-fill wait.
  - A requester deasserting mid-fill does not abort it.
  - A req still high on return to IDLE is re-arbitrated in IDLE (one idle cycle minimum between grants).

- mem_data_valid in IDLE or WRITE is ignored.
- mem_data_in is 0 whenever mem_wr=0.
- Address arithmetic is 16-bit; base+2k never crosses a block, so there is no wrap-around.

Optional Feature:
MEM_ARB_RR_EN.
- Defined: between the two fill requesters, the one not served by the most recent fill wins ties. The last-fill flag resets to I-cache, so the D-cache wins the first tie. dwrite_req keeps top priority.
- Undefined: fixed D-over-I priority as above.

Test Plan:
- D-cache fill, dcache_addr=0x1236 → dcache_grant rises one cycle later. Reads are issued to 0x1230,0x1232,…,0x123E on 8 consecutive cycles. Exactly 8 dcache_data_valid pulses occur. Grant drops on the 8th valid.
- I-cache fill at 0xABCF → reads 0xABC0..0xABCE; icache_data_valid pulses 8 times; dcache_data_valid stays 0.
- Simultaneous dwrite_req (0x0040, data 0xBEEF), dcache_req and icache_req in IDLE:
  - WRITE occurs first: mem_wr=1, addr 0x0040, data 0xBEEF, ack for 1 cycle.
  - Then a D fill, then an I fill.
- dwrite_req asserted mid-D-fill → no write until the fill completes and state returns to IDLE; the ack follows two cycles after completion.
- Reset asserted after 3 valids of a fill → outputs 0 next cycle. The remaining 5 valids produce no *_data_valid, and the next request is granted normally.
- With MEM_ARB_RR_EN, both fill reqs held continuously → grants alternate D, I, D, I. Without it → D only while dcache_req holds.
